// File: rtl/synth_pkg.sv
// Shared synth types: ADSR state encoding and the common audio sample width.
package synth_pkg;

  localparam int SAMPLE_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    ATTACK,
    DECAY,
    SUSTAIN,
    RELEASE
  } adsr_state_t;

endpackage

// File: rtl/adsr_envelope_sample_scaler.sv
// sample_scaler: captures sample/envelope on tick, registers the signed x unsigned
// product, and presents product >>> ENV_WIDTH with a one-cycle valid strobe.
module sample_scaler
  import synth_pkg::*;
#(
  parameter int SAMPLE_WIDTH = SAMPLE_W,
  parameter int ENV_WIDTH    = 16
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           tick_in,
  input  logic signed [SAMPLE_WIDTH-1:0] sample_in,
  input  logic        [ENV_WIDTH-1:0]    env_in,
  output logic signed [SAMPLE_WIDTH-1:0] sample_out,
  output logic                           valid_out
);

  localparam int PROD_W = SAMPLE_WIDTH + ENV_WIDTH;

  logic signed [SAMPLE_WIDTH-1:0] sample_cap_q, sample_cap_d;
  logic        [ENV_WIDTH-1:0]    env_cap_q, env_cap_d;
  logic                           cap_vld_q, cap_vld_d;
  logic signed [PROD_W-1:0]       prod_q, prod_d;
  logic                           prod_vld_q, prod_vld_d;
  logic signed [PROD_W:0]         mult;

  always_comb begin
    sample_cap_d = sample_cap_q;
    env_cap_d    = env_cap_q;
    cap_vld_d    = tick_in;
    prod_d       = prod_q;
    prod_vld_d   = cap_vld_q;
    // Envelope zero-extended so the multiply stays signed; magnitude fits PROD_W bits.
    mult = sample_cap_q * $signed({1'b0, env_cap_q});
    if (tick_in) begin
      sample_cap_d = sample_in;
      env_cap_d    = env_in;
    end
    if (cap_vld_q) begin
      prod_d = PROD_W'(mult);
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      sample_cap_q <= '0;
      env_cap_q    <= '0;
      cap_vld_q    <= 1'b0;
      prod_q       <= '0;
      prod_vld_q   <= 1'b0;
    end else begin
      sample_cap_q <= sample_cap_d;
      env_cap_q    <= env_cap_d;
      cap_vld_q    <= cap_vld_d;
      prod_q       <= prod_d;
      prod_vld_q   <= prod_vld_d;
    end
  end

  assign sample_out = SAMPLE_WIDTH'(prod_q >>> ENV_WIDTH);
  assign valid_out  = prod_vld_q;

endmodule

// File: rtl/adsr_envelope.sv
// Per-voice ADSR envelope with saturating arithmetic, stepped on sample_tick.
// Define ADSR_EXP_RELEASE_EN for exponential release (env -= max(env>>RELEASE_SHIFT,1)).
module adsr_envelope
  import synth_pkg::*;
#(
  parameter int                   SAMPLE_WIDTH  = SAMPLE_W,
  parameter int                   ENV_WIDTH     = 16,
  parameter logic [ENV_WIDTH-1:0] ATTACK_STEP   = 16'd64,
  parameter logic [ENV_WIDTH-1:0] DECAY_STEP    = 16'd16,
  parameter logic [ENV_WIDTH-1:0] SUSTAIN_LEVEL = 16'h8000,
  parameter logic [ENV_WIDTH-1:0] RELEASE_STEP  = 16'd8,
  parameter int                   RELEASE_SHIFT = 8
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           sample_tick,
  input  logic                           gate_in,
  input  logic                           trigger_in,
  input  logic signed [SAMPLE_WIDTH-1:0] sample_in,
  output logic signed [SAMPLE_WIDTH-1:0] sample_out,
  output logic                           sample_valid_out,
  output logic                           active_out,
  output logic        [ENV_WIDTH-1:0]    env_out
);

  localparam logic [ENV_WIDTH-1:0] ENV_MAX = '1;

  if (RELEASE_SHIFT >= ENV_WIDTH || RELEASE_STEP == '0) begin : g_bad_cfg
    $error("adsr_envelope: RELEASE_SHIFT must be < ENV_WIDTH and RELEASE_STEP nonzero");
  end

  adsr_state_t          state_q, state_d;
  logic [ENV_WIDTH-1:0] env_q, env_d;
  logic                 pending_q, pending_d;

  logic [ENV_WIDTH:0]   attack_sum;
  logic [ENV_WIDTH:0]   decay_diff;
  logic [ENV_WIDTH-1:0] rel_step;
  logic                 go_attack;

  always_comb begin
    attack_sum = {1'b0, env_q} + {1'b0, ATTACK_STEP};
    decay_diff = {1'b0, env_q} - {1'b0, DECAY_STEP};
`ifdef ADSR_EXP_RELEASE_EN
    rel_step = env_q >> RELEASE_SHIFT;
    if (rel_step == '0) begin
      rel_step = ENV_WIDTH'(1);
    end
`else
    rel_step = RELEASE_STEP;
`endif
  end

  // A trigger in the tick cycle itself counts as pending.
  assign go_attack = (pending_q || trigger_in) && gate_in;

  always_comb begin
    state_d   = state_q;
    env_d     = env_q;
    pending_d = pending_q || trigger_in;

    if (sample_tick) begin
      pending_d = 1'b0;
      // Retrigger enters ATTACK and applies the attack step to the current level.
      if (go_attack || (state_q == ATTACK && gate_in)) begin
        if (attack_sum >= {1'b0, ENV_MAX}) begin
          env_d   = ENV_MAX;
          state_d = DECAY;
        end else begin
          env_d   = attack_sum[ENV_WIDTH-1:0];
          state_d = ATTACK;
        end
      end else begin
        unique case (state_q)
          IDLE: ;
          ATTACK: state_d = RELEASE;
          DECAY: begin
            if (!gate_in) begin
              state_d = RELEASE;
            end else if (decay_diff[ENV_WIDTH] ||
                         decay_diff[ENV_WIDTH-1:0] <= SUSTAIN_LEVEL) begin
              env_d   = SUSTAIN_LEVEL;
              state_d = SUSTAIN;
            end else begin
              env_d = decay_diff[ENV_WIDTH-1:0];
            end
          end
          SUSTAIN: begin
            if (!gate_in) state_d = RELEASE;
          end
          RELEASE: begin
            if (env_q <= rel_step) begin
              env_d   = '0;
              state_d = IDLE;
            end else begin
              env_d = env_q - rel_step;
            end
          end
          default: begin
            env_d   = '0;
            state_d = IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q   <= IDLE;
      env_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      env_q     <= env_d;
      pending_q <= pending_d;
    end
  end

  sample_scaler #(
    .SAMPLE_WIDTH(SAMPLE_WIDTH),
    .ENV_WIDTH   (ENV_WIDTH)
  ) u_scaler (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .tick_in   (sample_tick),
    .sample_in (sample_in),
    .env_in    (env_q),
    .sample_out(sample_out),
    .valid_out (sample_valid_out)
  );

  assign active_out = (state_q != IDLE);
  assign env_out    = env_q;

endmodule
